hbridge_gate_sequencer: RTL and testbench

Output stage between the dead-time block and the H-bridge gate drivers. Takes the dead-timed gate vector from the control law and sequences start-up: all off, then bootstrap precharge, then forced sigma=1, then run. Guards the bridge at run time with shoot-through detection and a stalled-switching watchdog, latching faults until an explicit clear.

---
 rtl/hbridge_gate_sequencer.sv | 173 +++++++++++++++++
 tb/tb_hbridge_gate_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hbridge_gate_sequencer.sv
// ============================================================================
// hbridge_gate_sequencer
// Start-up sequencer and run-time guard between the dead-time block and the
// H-bridge gate drivers (precharge, forced vector, run, latched faults).
// Revision: 1.0
// ============================================================================
`default_nettype none

module hbridge_gate_sequencer #(
  parameter int unsigned BOOT_CYCLES  = 1000,
  parameter int unsigned FORCE_CYCLES = 1000,
  parameter int unsigned WDOG_CYCLES  = 50000,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       i_clock,
  input  logic       i_RESET,
  input  logic       i_enable,
  input  logic [3:0] i_gate,
  input  logic       i_fault_clear,
  output logic [3:0] o_gate,
  output logic [2:0] o_state,
  output logic       o_running,
  output logic       o_fault,
  output logic [1:0] o_fault_code
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BOOT  = 3'd1,
    ST_FORCE = 3'd2,
    ST_RUN   = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] c_boot_last  = CNT_W'(BOOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_force_last = CNT_W'(FORCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_wdog       = CNT_W'(WDOG_CYCLES);
  localparam logic [3:0]       c_gate_off   = 4'b0000;
  localparam logic [3:0]       c_gate_boot  = 4'b1100;
  localparam logic [3:0]       c_gate_force = 4'b1001;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       gate_q, gate_d;
  logic [3:0]       prev_gate_q, prev_gate_d;
  logic             running_q, running_d;
  logic             fault_q, fault_d;
  logic [1:0]       code_q, code_d;

  logic             w_shoot;
  logic             w_changed;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_wd_next;

  always_comb begin
    w_shoot   = (i_gate[0] & i_gate[2]) | (i_gate[1] & i_gate[3]);
    w_changed = (i_gate != prev_gate_q);
    w_cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    w_wd_next = w_changed ? {CNT_W{1'b0}} : w_cnt_inc;

    state_d     = state_q;
    cnt_d       = cnt_q;
    gate_d      = c_gate_off;
    prev_gate_d = i_gate;
    running_d   = 1'b0;
    fault_d     = fault_q;
    code_d      = code_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (i_enable) begin
          state_d = ST_BOOT;
          gate_d  = c_gate_boot;
        end
      end

      ST_BOOT: begin
        if (!i_enable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == c_boot_last) begin
          state_d = ST_FORCE;
          cnt_d   = '0;
          gate_d  = c_gate_force;
        end else begin
          cnt_d  = w_cnt_inc;
          gate_d = c_gate_boot;
        end
      end

      ST_FORCE: begin
        if (!i_enable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == c_force_last) begin
          // Hand-over edge: an illegal command is still never driven out.
          state_d   = ST_RUN;
          cnt_d     = '0;
          gate_d    = w_shoot ? c_gate_off : i_gate;
          running_d = 1'b1;
        end else begin
          cnt_d  = w_cnt_inc;
          gate_d = c_gate_force;
        end
      end

      ST_RUN: begin
        if (!i_enable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (w_shoot) begin
          state_d = ST_FAULT;
          cnt_d   = '0;
          fault_d = 1'b1;
          code_d  = 2'b01;
        end else if (w_wd_next >= c_wdog) begin
          state_d = ST_FAULT;
          cnt_d   = '0;
          fault_d = 1'b1;
          code_d  = 2'b10;
        end else begin
          cnt_d     = w_wd_next;
          gate_d    = i_gate;
          running_d = 1'b1;
        end
      end

      ST_FAULT: begin
        cnt_d = '0;
        if (i_fault_clear && !i_enable) begin
          state_d = ST_IDLE;
          fault_d = 1'b0;
          code_d  = 2'b00;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_RESET) begin
    if (!i_RESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      gate_q      <= c_gate_off;
      prev_gate_q <= 4'b0000;
      running_q   <= 1'b0;
      fault_q     <= 1'b0;
      code_q      <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gate_q      <= gate_d;
      prev_gate_q <= prev_gate_d;
      running_q   <= running_d;
      fault_q     <= fault_d;
      code_q      <= code_d;
    end
  end

  assign o_gate       = gate_q;
  assign o_state      = state_q;
  assign o_running    = running_q;
  assign o_fault      = fault_q;
  assign o_fault_code = code_q;

endmodule

`default_nettype wire

// File: tb/tb_hbridge_gate_sequencer.sv
// ============================================================================
// tb_hbridge_gate_sequencer
// Scenario tasks plus a randomized run against a timestamp-based reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hbridge_gate_sequencer;

  localparam int BOOT  = 4;
  localparam int FORCE = 3;
  localparam int WDOG  = 10;

  logic       clk;
  logic       i_RESET;
  logic       i_enable;
  logic [3:0] i_gate;
  logic       i_fault_clear;
  logic [3:0] o_gate;
  logic [2:0] o_state;
  logic       o_running;
  logic       o_fault;
  logic [1:0] o_fault_code;

  int checks = 0;
  int errors = 0;

  hbridge_gate_sequencer #(
    .BOOT_CYCLES (BOOT),
    .FORCE_CYCLES(FORCE),
    .WDOG_CYCLES (WDOG),
    .CNT_W       (16)
  ) dut (
    .i_clock      (clk),
    .i_RESET      (i_RESET),
    .i_enable     (i_enable),
    .i_gate       (i_gate),
    .i_fault_clear(i_fault_clear),
    .o_gate       (o_gate),
    .o_state      (o_state),
    .o_running    (o_running),
    .o_fault      (o_fault),
    .o_fault_code (o_fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phases derived from cycle timestamps.
  logic [2:0] m_state;
  logic [3:0] m_gate;
  logic       m_running;
  logic       m_fault;
  logic [1:0] m_code;
  logic [3:0] m_prev;
  int         m_start;
  int         m_last_change;
  int         cyc = 0;

  function automatic logic is_shoot(input logic [3:0] g);
    return (g[0] & g[2]) | (g[1] & g[3]);
  endfunction

  task automatic model_reset();
    m_state = 3'd0; m_gate = 4'b0000; m_running = 1'b0;
    m_fault = 1'b0; m_code = 2'b00;   m_prev = 4'b0000;
    m_start = 0;    m_last_change = 0;
  endtask

  task automatic model_go_idle();
    m_state = 3'd0; m_gate = 4'b0000; m_running = 1'b0;
  endtask

  task automatic model_fault(input logic [1:0] code);
    m_state = 3'd4; m_gate = 4'b0000; m_running = 1'b0;
    m_fault = 1'b1; m_code = code;
  endtask

  task automatic model_step();
    logic sh, ch;
    int   k;
    sh = is_shoot(i_gate);
    ch = (i_gate != m_prev);
    m_prev = i_gate;
    if (m_state == 3'd0) begin
      if (i_enable) begin
        m_state = 3'd1; m_gate = 4'b1100; m_start = cyc;
      end else model_go_idle();
    end else if (m_state == 3'd1 || m_state == 3'd2) begin
      if (!i_enable) model_go_idle();
      else begin
        k = cyc - m_start;
        if (k < BOOT) begin
          m_state = 3'd1; m_gate = 4'b1100;
        end else if (k < BOOT + FORCE) begin
          m_state = 3'd2; m_gate = 4'b1001;
        end else begin
          m_state = 3'd3; m_running = 1'b1; m_last_change = cyc;
          m_gate = sh ? 4'b0000 : i_gate;
        end
      end
    end else if (m_state == 3'd3) begin
      if (!i_enable) model_go_idle();
      else if (sh) model_fault(2'b01);
      else begin
        if (ch) m_last_change = cyc;
        if (cyc - m_last_change >= WDOG) model_fault(2'b10);
        else begin
          m_gate = i_gate; m_running = 1'b1;
        end
      end
    end else begin
      if (i_fault_clear && !i_enable) begin
        model_go_idle(); m_fault = 1'b0; m_code = 2'b00;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    i_RESET = 1'b0; i_enable = 1'b0; i_fault_clear = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    i_RESET = 1'b1;
  endtask

  task automatic test_reset();
    i_gate = 4'b1001;
    do_reset();
    checks++;
    if ({o_state, o_gate, o_running, o_fault, o_fault_code} !== 11'd0) begin
      errors++;
      $display("FAIL reset_state got st=%0d g=%b run=%b f=%b c=%b want all zero",
               o_state, o_gate, o_running, o_fault, o_fault_code);
    end
    tick();
    checks++;
    if (o_state !== 3'd0 || o_gate !== 4'b0000) begin
      errors++;
      $display("FAIL idle_hold got st=%0d g=%b want st=0 g=0000", o_state, o_gate);
    end
  endtask

  task automatic test_startup();
    logic [3:0] exp_g;
    logic [2:0] exp_s;
    i_gate = 4'b1001;
    i_enable = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      exp_g = (e <= BOOT) ? 4'b1100 : (e <= BOOT + FORCE) ? 4'b1001 : i_gate;
      exp_s = (e <= BOOT) ? 3'd1 : (e <= BOOT + FORCE) ? 3'd2 : 3'd3;
      checks++;
      if (o_gate !== exp_g || o_state !== exp_s) begin
        errors++;
        $display("FAIL startup_edge%0d got st=%0d g=%b want st=%0d g=%b",
                 e, o_state, o_gate, exp_s, exp_g);
      end
      checks++;
      if ({o_state, o_gate, o_running, o_fault, o_fault_code} !==
          {m_state, m_gate, m_running, m_fault, m_code}) begin
        errors++;
        $display("FAIL startup_model got st=%0d g=%b run=%b want st=%0d g=%b run=%b",
                 o_state, o_gate, o_running, m_state, m_gate, m_running);
      end
    end
    i_gate = 4'b0110;
    tick();
    checks++;
    if (o_gate !== 4'b0110 || o_running !== 1'b1) begin
      errors++;
      $display("FAIL run_passthrough got g=%b run=%b want g=0110 run=1", o_gate, o_running);
    end
  endtask

  task automatic test_shoot_through();
    i_gate = 4'b0101;
    tick();
    checks++;
    if (o_gate !== 4'b0000 || o_fault !== 1'b1 || o_fault_code !== 2'b01 || o_state !== 3'd4) begin
      errors++;
      $display("FAIL shoot_fault got g=%b f=%b c=%b st=%0d want g=0000 f=1 c=01 st=4",
               o_gate, o_fault, o_fault_code, o_state);
    end
    i_gate = 4'b0110;
    repeat (3) begin
      tick();
      checks++;
      if (o_gate !== 4'b0000 || o_state !== 3'd4) begin
        errors++;
        $display("FAIL shoot_hold got g=%b st=%0d want g=0000 st=4", o_gate, o_state);
      end
    end
  endtask

  task automatic test_fault_clear();
    int n_boot, n_force;
    i_fault_clear = 1'b1;
    i_enable = 1'b1;
    repeat (2) tick();
    checks++;
    if (o_state !== 3'd4 || o_fault !== 1'b1) begin
      errors++;
      $display("FAIL clear_ignored got st=%0d f=%b want st=4 f=1", o_state, o_fault);
    end
    i_enable = 1'b0;
    tick();
    checks++;
    if (o_state !== 3'd0 || o_fault !== 1'b0 || o_fault_code !== 2'b00) begin
      errors++;
      $display("FAIL clear_exit got st=%0d f=%b c=%b want st=0 f=0 c=00",
               o_state, o_fault, o_fault_code);
    end
    i_fault_clear = 1'b0;
    i_gate = 4'b1001;
    i_enable = 1'b1;
    n_boot = 0; n_force = 0;
    repeat (8) begin
      tick();
      if (o_gate == 4'b1100 && o_state == 3'd1) n_boot++;
      if (o_state == 3'd2) n_force++;
    end
    checks++;
    if (n_boot != BOOT || n_force != FORCE || o_state !== 3'd3) begin
      errors++;
      $display("FAIL restart_seq got boot=%0d force=%0d st=%0d want boot=%0d force=%0d st=3",
               n_boot, n_force, o_state, BOOT, FORCE);
    end
  endtask

  task automatic test_watchdog();
    logic bad;
    i_gate = 4'b0110; tick();
    i_gate = 4'b1001; tick();
    for (int j = 1; j <= WDOG; j++) begin
      tick();
      checks++;
      if (j < WDOG ? (o_state !== 3'd3) :
          (o_state !== 3'd4 || o_fault_code !== 2'b10 || o_gate !== 4'b0000)) begin
        errors++;
        $display("FAIL wdog_hold%0d got st=%0d c=%b g=%b", j, o_state, o_fault_code, o_gate);
      end
    end
    i_enable = 1'b0; i_fault_clear = 1'b1; tick();
    i_enable = 1'b1; i_fault_clear = 1'b0;
    repeat (8) tick();
    bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (i % 9 == 0) i_gate = (i_gate == 4'b1001) ? 4'b0110 : 4'b1001;
      tick();
      if (o_state !== 3'd3 || o_fault !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL wdog_toggle9 got st=%0d f=%b want st=3 f=0", o_state, o_fault);
    end
  endtask

  task automatic test_abort();
    int n_boot;
    i_enable = 1'b0; tick();
    i_enable = 1'b1; tick(); tick();
    i_enable = 1'b0; tick();
    checks++;
    if (o_state !== 3'd0 || o_gate !== 4'b0000) begin
      errors++;
      $display("FAIL abort_idle got st=%0d g=%b want st=0 g=0000", o_state, o_gate);
    end
    i_enable = 1'b1;
    n_boot = 0;
    repeat (8) begin
      tick();
      if (o_gate == 4'b1100) n_boot++;
    end
    checks++;
    if (n_boot != BOOT || o_state !== 3'd3) begin
      errors++;
      $display("FAIL abort_restart got boot=%0d st=%0d want boot=%0d st=3", n_boot, o_state, BOOT);
    end
  endtask

  task automatic test_async_reset();
    i_gate = 4'b0110;
    tick();
    checks++;
    if (o_gate !== 4'b0110) begin
      errors++;
      $display("FAIL async_pre got g=%b want 0110", o_gate);
    end
    #3;
    i_RESET = 1'b0;
    #1;
    checks++;
    if (o_gate !== 4'b0000 || o_state !== 3'd0 || o_running !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got g=%b st=%0d run=%b want g=0000 st=0 run=0",
               o_gate, o_state, o_running);
    end
    i_enable = 1'b0;
    model_reset();
    @(negedge clk);
    i_RESET = 1'b1;
  endtask

  task automatic test_random();
    logic [3:0] g;
    for (int n = 0; n < 3000; n++) begin
      if (m_state == 3'd4) i_enable = ($urandom_range(0, 3) != 0);
      else i_enable = ($urandom_range(0, 99) < 97);
      i_fault_clear = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) begin
        g = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 39) != 0)
          for (int t = 0; t < 32 && is_shoot(g); t++) g = 4'($urandom_range(0, 15));
        if (is_shoot(g) && $urandom_range(0, 1) == 0) g = 4'b1001;
        i_gate = g;
      end
      tick();
      checks++;
      if ({o_state, o_gate, o_running, o_fault, o_fault_code} !==
          {m_state, m_gate, m_running, m_fault, m_code}) begin
        errors++;
        $display("FAIL random_cyc%0d got st=%0d g=%b run=%b f=%b c=%b want st=%0d g=%b run=%b f=%b c=%b",
                 n, o_state, o_gate, o_running, o_fault, o_fault_code,
                 m_state, m_gate, m_running, m_fault, m_code);
      end
    end
  endtask

  initial begin
    i_RESET = 1'b0; i_enable = 1'b0; i_gate = 4'b0000; i_fault_clear = 1'b0;
    test_reset();
    test_startup();
    test_shoot_through();
    test_fault_clear();
    test_watchdog();
    test_abort();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
